// File: rtl/resetreq_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// resetreq_ctrl
//
// Reset-request controller feeding the rstreq input of the reset generator.
// Three causes are merged into one registered, fixed-length rstreq pulse:
//   * short press of the front-panel reset button (debounced, active-low pin)
//   * software request strobe carrying the correct key
//   * watchdog timeout (no kick for WDT_LIMIT cycles while enabled)
// A long button press never requests reset; it raises a one-cycle longpress
// event instead (power-off handling). The most recent accepted cause is held
// in `cause` and survives the requested reset, because `reset` here is the
// power-on reset only and must not be driven from rstreq.
//
// Parameters
//   DEB_CYCLES  stable-input cycles needed to accept a button level change
//   LONG_CYCLES press length that counts as a long press
//   PULSE_LEN   rstreq high time in cycles
//   WDT_LIMIT   watchdog cycles without kick before timeout
//   SW_KEY      key value that validates a software request
//
// Ports
//   clk          system clock
//   reset        power-on reset, synchronous, active-high
//   btn_n        raw reset button, active-low, asynchronous to clk
//   sw_req       one-cycle software request strobe
//   sw_key       key sampled together with sw_req
//   wdt_en       watchdog enable (level)
//   wdt_kick     one-cycle watchdog service strobe
//   rstreq       registered reset request, PULSE_LEN cycles long
//   longpress    one-cycle pulse when a press reaches LONG_CYCLES
//   btn_pressed  debounced button state, 1 = pressed
//   cause        last accepted cause: 0 none, 1 button, 2 software, 3 watchdog
//   dbg_state    FSM state for observation: 0 = IDLE, 1 = ASSERT
//
// Handshake: there is no back-pressure anywhere. Every request input is a
// plain strobe or level sampled on each rising clk edge; an event is either
// accepted in the cycle it is present (FSM in IDLE) or dropped for good.
// ---------------------------------------------------------------------------
module resetreq_ctrl #(
  parameter logic [15:0] DEB_CYCLES  = 16'd50000,
  parameter logic [31:0] LONG_CYCLES = 32'd100000000,
  parameter logic [7:0]  PULSE_LEN   = 8'd16,
  parameter logic [31:0] WDT_LIMIT   = 32'd200000000,
  parameter logic [7:0]  SW_KEY      = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_n,
  input  logic       sw_req,
  input  logic [7:0] sw_key,
  input  logic       wdt_en,
  input  logic       wdt_kick,
  output logic       rstreq,
  output logic       longpress,
  output logic       btn_pressed,
  output logic [1:0] cause,
  output logic       dbg_state
);

  // Counter widths: enough bits to hold the limit value itself.
  localparam int DW = $clog2(DEB_CYCLES) + 1;
  localparam int PW = $clog2(LONG_CYCLES) + 1;
  localparam int TW = $clog2(PULSE_LEN) + 1;
  localparam int WW = $clog2(WDT_LIMIT) + 1;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 16'd1);
  localparam logic [PW-1:0] LONG_MAX  = PW'(LONG_CYCLES);
  localparam logic [PW-1:0] LONG_LAST = PW'(LONG_CYCLES - 32'd1);
  localparam logic [TW-1:0] PULSE_LD  = TW'(PULSE_LEN - 8'd1);
  localparam logic [WW-1:0] WDT_LAST  = WW'(WDT_LIMIT - 32'd1);

  localparam logic [1:0] CAUSE_BTN = 2'd1;
  localparam logic [1:0] CAUSE_SW  = 2'd2;
  localparam logic [1:0] CAUSE_WDT = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ASSERT = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Two-flop synchronizer. Both flops reset to 1 (released) so that a button
  // held across reset is seen as a fresh press afterwards.
  // -------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
    end
  end

  // -------------------------------------------------------------------------
  // Debounce. r_stable is the accepted pin level (1 = released). The counter
  // runs only while the synchronized level disagrees with it; any agreeing
  // sample restarts the qualification window.
  // -------------------------------------------------------------------------
  logic [DW-1:0] r_deb_cnt;
  logic          r_stable;
  logic          r_stable_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_deb_cnt  <= '0;
      r_stable   <= 1'b1;
      r_stable_d <= 1'b1;
    end else begin
      r_stable_d <= r_stable;
      if (r_sync2 == r_stable) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_LAST) begin
        r_stable  <= r_sync2;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DW'(1);
      end
    end
  end

  assign btn_pressed = ~r_stable;

  // -------------------------------------------------------------------------
  // Press timer. Saturates at LONG_CYCLES so a very long hold never wraps
  // back into the short-press range. longpress fires on the single edge where
  // the count steps from LONG_CYCLES-1 to LONG_CYCLES.
  // -------------------------------------------------------------------------
  logic [PW-1:0] r_press_cnt;
  logic          r_longpress;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_press_cnt <= '0;
      r_longpress <= 1'b0;
    end else begin
      r_longpress <= ~r_stable && (r_press_cnt == LONG_LAST);
      if (r_stable) begin
        r_press_cnt <= '0;
      end else if (r_press_cnt != LONG_MAX) begin
        r_press_cnt <= r_press_cnt + PW'(1);
      end
    end
  end

  assign longpress = r_longpress;

  // -------------------------------------------------------------------------
  // Event sources
  // -------------------------------------------------------------------------
  state_t r_state;
  logic   w_release;
  logic   w_btn_evt;
  logic   w_sw_evt;
  logic   w_wdt_evt;
  logic   w_any_evt;

  // Release is seen one cycle after the stable level returns to 1; press_cnt
  // still holds the completed press length in that cycle (it clears on the
  // following edge), so the short/long decision uses the full duration.
  assign w_release = r_stable & ~r_stable_d;
  assign w_btn_evt = w_release & (r_press_cnt < LONG_MAX);
  assign w_sw_evt  = sw_req & (sw_key == SW_KEY);

  // -------------------------------------------------------------------------
  // Watchdog. Held at zero while disabled, on a kick, and while a pulse is
  // being driven, so the timeout window restarts after every request.
  // -------------------------------------------------------------------------
  logic [WW-1:0] r_wdt_cnt;

  assign w_wdt_evt = wdt_en & ~wdt_kick & (r_wdt_cnt == WDT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wdt_cnt <= '0;
    end else if (!wdt_en || wdt_kick || (r_state != ST_IDLE) || w_wdt_evt) begin
      r_wdt_cnt <= '0;
    end else begin
      r_wdt_cnt <= r_wdt_cnt + WW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Cause selection for coinciding events: button > watchdog > software.
  // -------------------------------------------------------------------------
  logic [1:0] w_next_cause;

  assign w_any_evt = w_btn_evt | w_wdt_evt | w_sw_evt;

  always_comb begin
    w_next_cause = CAUSE_SW;
    if (w_btn_evt) begin
      w_next_cause = CAUSE_BTN;
    end else if (w_wdt_evt) begin
      w_next_cause = CAUSE_WDT;
    end
  end

  // -------------------------------------------------------------------------
  // Pulse FSM. rstreq and cause are registered here, so cause changes on the
  // same edge that raises rstreq. Events seen in ASSERT are discarded.
  // -------------------------------------------------------------------------
  logic [TW-1:0] r_pulse_cnt;
  logic          r_rstreq;
  logic [1:0]    r_cause;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pulse_cnt <= '0;
      r_rstreq    <= 1'b0;
      r_cause     <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_evt) begin
            r_state     <= ST_ASSERT;
            r_pulse_cnt <= PULSE_LD;
            r_rstreq    <= 1'b1;
            r_cause     <= w_next_cause;
          end
        end
        ST_ASSERT: begin
          if (r_pulse_cnt == '0) begin
            r_state  <= ST_IDLE;
            r_rstreq <= 1'b0;
          end else begin
            r_pulse_cnt <= r_pulse_cnt - TW'(1);
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_rstreq <= 1'b0;
        end
      endcase
    end
  end

  assign rstreq    = r_rstreq;
  assign cause     = r_cause;
  assign dbg_state = (r_state == ST_ASSERT);

endmodule
